// File: rtl/sr_wb_shift_reg_if.sv
// Wishbone slave bus bundle for the shift-register peripheral.
// The management SoC drives the master side; the peripheral takes the slave side.
interface sr_wb_shift_reg_if;
   logic        wbs_cyc_i;
   logic        wbs_stb_i;
   logic        wbs_we_i;
   logic [3:0]  wbs_sel_i;
   logic [31:0] wbs_adr_i;
   logic [31:0] wbs_dat_i;
   logic        wbs_ack_o;
   logic [31:0] wbs_dat_o;

   modport master (
      output wbs_cyc_i, wbs_stb_i, wbs_we_i,
      output wbs_sel_i, wbs_adr_i, wbs_dat_i,
      input  wbs_ack_o, wbs_dat_o
   );

   modport slave (
      input  wbs_cyc_i, wbs_stb_i, wbs_we_i,
      input  wbs_sel_i, wbs_adr_i, wbs_dat_i,
      output wbs_ack_o, wbs_dat_o
   );
endinterface

// File: rtl/sr_wb_shift_reg.sv
// Wishbone slave serial shift register with programmable
// direction, shift count and shift rate; IRQ on completion.
module sr_wb_shift_reg #(
   parameter int          WIDTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
   input  logic             clock,
   input  logic             resetb,
   sr_wb_shift_reg_if.slave wb,
   input  logic             ser_in,
   output logic             ser_out,
   output logic             busy,
   output logic             irq
);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q;
   logic             ctrl_dir_q;
   logic [5:0]       ctrl_len_q;
   logic             run_dir_q;
   logic [5:0]       cnt_q;
   logic [15:0]      div_q;
   logic [15:0]      tick_q;
   logic             done_q;
   logic             ack_q;
   logic [31:0]      dat_q;

   logic        page_hit, reg_hit, access, wr_en;
   logic [1:0]  idx;
   logic        wr_ctrl, wr_data, wr_stat, wr_div;
   logic [31:0] ctrl_cur, ctrl_new, status_w, div_mrg, rdata;
   logic [5:0]  run_len;
   logic        start_req, go, zero_go, shift_en, last;
   logic        unused_bits;

   function automatic logic [31:0] merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  sel
   );
      logic [31:0] r;
      for (int b = 0; b < 4; b++)
         r[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
      return r;
   endfunction

   // Registers decode on adr[31:4]; the rest of the 256-byte
   // page still acks (reads 0, writes dropped) so firmware never stalls.
   assign page_hit = wb.wbs_adr_i[31:8] == BASE_ADDR[31:8];
   assign reg_hit  = wb.wbs_adr_i[31:4] == BASE_ADDR[31:4];
   assign access   = wb.wbs_cyc_i & wb.wbs_stb_i & page_hit & ~ack_q;
   assign wr_en    = access & wb.wbs_we_i & reg_hit;
   assign idx      = wb.wbs_adr_i[3:2];
   assign wr_ctrl  = wr_en & (idx == 2'd0);
   assign wr_data  = wr_en & (idx == 2'd1);
   assign wr_stat  = wr_en & (idx == 2'd2);
   assign wr_div   = wr_en & (idx == 2'd3);

   assign ctrl_cur  = {18'b0, ctrl_len_q, 6'b0, ctrl_dir_q, 1'b0};
   assign ctrl_new  = merge(ctrl_cur, wb.wbs_dat_i, wb.wbs_sel_i);
   assign start_req = wr_ctrl & ctrl_new[0];
   assign run_len   = (ctrl_new[13:8] > 6'd32) ? 6'd32 : ctrl_new[13:8];
   assign div_mrg   = merge({16'b0, div_q}, wb.wbs_dat_i, wb.wbs_sel_i);
   assign status_w  = {18'b0, cnt_q, 6'b0, done_q, busy};

   assign unused_bits = ^{ctrl_new[31:14], ctrl_new[7:2],
                          div_mrg[31:16], wb.wbs_adr_i[1:0]};

   always_comb begin
      rdata = '0;
      if (reg_hit) begin
         unique case (1'b1)
            (idx == 2'd0): rdata = ctrl_cur;
            (idx == 2'd1): rdata = sr_q;
            (idx == 2'd2): rdata = status_w;
            (idx == 2'd3): rdata = {16'b0, div_q};
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      go       = 1'b0;
      zero_go  = 1'b0;
      shift_en = 1'b0;
      last     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_req) begin
               if (run_len != 6'd0) begin
                  go      = 1'b1;
                  state_d = SHIFT;
               end else begin
                  zero_go = 1'b1;
               end
            end
         end
         SHIFT: begin
            if (tick_q == div_q) begin
               shift_en = 1'b1;
               if (cnt_q == 6'd1) begin
                  last    = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clock or negedge resetb) begin
      if (!resetb) begin
         sr_q       <= '0;
         ctrl_dir_q <= 1'b0;
         ctrl_len_q <= '0;
         run_dir_q  <= 1'b0;
         cnt_q      <= '0;
         div_q      <= '0;
         tick_q     <= '0;
         done_q     <= 1'b0;
         ack_q      <= 1'b0;
         dat_q      <= '0;
      end else begin
         ack_q <= access;
         dat_q <= (access & ~wb.wbs_we_i) ? rdata : '0;
         if (wr_ctrl) begin
            ctrl_dir_q <= ctrl_new[1];
            ctrl_len_q <= ctrl_new[13:8];
         end
         if (wr_data && !busy)
            sr_q <= merge(sr_q, wb.wbs_dat_i, wb.wbs_sel_i);
         if (wr_div && !busy)
            div_q <= div_mrg[15:0];
         if (go) begin
            run_dir_q <= ctrl_new[1];
            cnt_q     <= run_len;
            tick_q    <= '0;
         end else if (shift_en) begin
            sr_q   <= run_dir_q ? {ser_in, sr_q[WIDTH-1:1]}
                                : {sr_q[WIDTH-2:0], ser_in};
            cnt_q  <= cnt_q - 6'd1;
            tick_q <= '0;
         end else if (busy) begin
            tick_q <= tick_q + 16'd1;
         end
         // Completion beats a same-cycle write-1-to-clear.
         if (last || zero_go)
            done_q <= 1'b1;
         else if (go)
            done_q <= 1'b0;
         else if (wr_stat && wb.wbs_sel_i[0] && wb.wbs_dat_i[1])
            done_q <= 1'b0;
      end
   end

   assign busy         = (state_q == SHIFT);
   assign irq          = done_q;
   assign ser_out      = (busy ? run_dir_q : ctrl_dir_q) ? sr_q[0]
                                                         : sr_q[WIDTH-1];
   assign wb.wbs_ack_o = ack_q;
   assign wb.wbs_dat_o = dat_q;

endmodule

// File: tb/tb_sr_wb_shift_reg.sv
// Scoreboarded bench for sr_wb_shift_reg: bus reads are checked
// by a monitor; shift runs are compared against an arithmetic model.
module tb_sr_wb_shift_reg;

   localparam logic [31:0] BASE = 32'h3000_0000;

   logic clock = 1'b0;
   logic resetb = 1'b0;
   logic ser_in = 1'b0;
   logic ser_out, busy, irq;

   sr_wb_shift_reg_if wb ();

   sr_wb_shift_reg #(.WIDTH(32), .BASE_ADDR(BASE)) dut (
      .clock   (clock),
      .resetb  (resetb),
      .wb      (wb.slave),
      .ser_in  (ser_in),
      .ser_out (ser_out),
      .busy    (busy),
      .irq     (irq)
   );

   always #5 clock = ~clock;

   int unsigned cyc_n = 0;
   always @(posedge clock) cyc_n++;

   int chk_cnt = 0;
   int pass_cnt = 0;
   int unsigned acc_edge = 0;

   bit          q_rd[$];
   logic [31:0] q_exp[$];
   string       q_nm[$];

   logic [31:0] m_data;

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %08h want %08h", nm, act, exp);
   endtask

   // Monitor: every ack consumes one scoreboard entry.
   logic prev_ack = 1'b0;
   always @(negedge clock) begin
      if (!resetb) begin
         prev_ack = 1'b0;
      end else begin
         if (wb.wbs_ack_o) begin
            check("ack_single", {31'b0, prev_ack}, 0);
            check("ack_expected", {31'b0, q_rd.size() != 0}, 1);
            if (q_rd.size() != 0) begin
               bit          r;
               logic [31:0] e;
               string       n;
               r = q_rd.pop_front();
               e = q_exp.pop_front();
               n = q_nm.pop_front();
               if (r) check(n, wb.wbs_dat_o, e);
            end
         end
         prev_ack = wb.wbs_ack_o;
      end
   end

   task automatic bus(input bit we, input logic [31:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel,
                      input logic [31:0] exp, input string nm,
                      input bit want_ack);
      int lat;
      bit got;
      lat = 0;
      got = 1'b0;
      if (want_ack) begin
         q_rd.push_back(!we);
         q_exp.push_back(exp);
         q_nm.push_back(nm);
      end
      acc_edge = cyc_n + 1;
      wb.wbs_cyc_i = 1'b1;
      wb.wbs_stb_i = 1'b1;
      wb.wbs_we_i  = we;
      wb.wbs_adr_i = adr;
      wb.wbs_dat_i = dat;
      wb.wbs_sel_i = sel;
      for (int i = 0; i < 4; i++) begin
         @(posedge clock);
         #1;
         lat++;
         if (wb.wbs_ack_o) begin
            got = 1'b1;
            break;
         end
      end
      if (want_ack) check({nm, "_ack_lat"}, got ? lat : 0, 1);
      else          check({nm, "_no_ack"}, {31'b0, got}, 0);
      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      @(posedge clock);
      #1;
      if (want_ack && !got && q_rd.size() != 0) begin
         void'(q_rd.pop_back());
         void'(q_exp.pop_back());
         void'(q_nm.pop_back());
      end
   endtask

   task automatic wr(input logic [7:0] off, input logic [31:0] d,
                     input logic [3:0] sel = 4'hF);
      bus(1'b1, BASE + {24'b0, off}, d, sel, '0, "wr", 1'b1);
   endtask

   task automatic rd(input logic [7:0] off, input logic [31:0] e,
                     input string nm);
      bus(1'b0, BASE + {24'b0, off}, '0, 4'hF, e, nm, 1'b1);
   endtask

   // Register contents after k shifts, from the shift rules alone.
   function automatic logic [31:0] ref_sr(input logic [31:0] d,
                                          input bit dir, input bit sin,
                                          input int k);
      logic [31:0] fill;
      fill = sin ? 32'hFFFF_FFFF : 32'h0;
      if (k >= 32) return fill;
      if (k == 0)  return d;
      if (!dir) return (d << k) | (fill >> (32 - k));
      return (d >> k) | (fill << (32 - k));
   endfunction

   function automatic int clamp(input int len);
      return (len > 32) ? 32 : len;
   endfunction

   task automatic do_run(input logic [31:0] d, input bit dir,
                         input int len, input int dv, input bit sin,
                         input string nm);
      int unsigned s;
      int n, per, k, shifts, bad;
      logic [31:0] e_sr;
      bit e_busy, e_ser;
      wr(8'h04, d);
      wr(8'h0C, dv);
      ser_in = sin;
      wr(8'h00, (len << 8) | (int'(dir) << 1) | 1);
      s   = acc_edge;
      n   = clamp(len);
      per = dv + 1;
      bad = 0;
      for (int g = 0; g < 2000; g++) begin
         k      = int'(cyc_n - s);
         shifts = (k / per < n) ? k / per : n;
         e_busy = shifts < n;
         e_sr   = ref_sr(d, dir, sin, shifts);
         e_ser  = dir ? e_sr[0] : e_sr[31];
         if (busy !== e_busy || ser_out !== e_ser) bad++;
         if (!e_busy) break;
         @(posedge clock);
         #1;
      end
      check({nm, "_busy_ser"}, bad, 0);
      m_data = ref_sr(d, dir, sin, n);
      rd(8'h04, m_data, {nm, "_data"});
      rd(8'h08, 32'h2, {nm, "_status"});
      check({nm, "_irq"}, {31'b0, irq}, 1);
   endtask

   initial begin
      int unsigned s;
      int k, rem, wait_n;
      logic [31:0] d;
      bit sin;

      wb.wbs_cyc_i = 1'b0;
      wb.wbs_stb_i = 1'b0;
      wb.wbs_we_i  = 1'b0;
      wb.wbs_sel_i = '0;
      wb.wbs_adr_i = '0;
      wb.wbs_dat_i = '0;
      repeat (3) @(posedge clock);
      #1;
      resetb = 1'b1;
      @(posedge clock);
      #1;

      check("rst_ser_out", {31'b0, ser_out}, 0);
      check("rst_irq", {31'b0, irq}, 0);
      check("rst_busy", {31'b0, busy}, 0);
      rd(8'h00, 0, "rst_ctrl");
      rd(8'h04, 0, "rst_data");
      rd(8'h08, 0, "rst_status");
      rd(8'h0C, 0, "rst_div");

      do_run(32'h0000_00A5, 1'b0, 8, 0, 1'b1, "left");
      check("left_data_lit", m_data, 32'h0000_A5FF);

      wr(8'h04, 32'h8000_0001);
      ser_in = 1'b0;
      check("right_ser_pre", {31'b0, ser_out}, 1);
      do_run(32'h8000_0001, 1'b1, 1, 0, 1'b0, "right");

      // Divider: remaining count observed along the run.
      wr(8'h0C, 32'd3);
      wr(8'h04, 32'h1234_5678);
      wr(8'h00, 32'h0401);
      s = acc_edge;
      for (int i = 0; i < 10; i++) begin
         k   = int'(cyc_n - s);
         rem = 4 - ((k / 4 < 4) ? k / 4 : 4);
         rd(8'h08, (rem << 8) | ((rem == 0) ? 2 : 0) | ((rem > 0) ? 1 : 0),
            "div_status");
      end
      do_run(32'hC3C3_0F0F, 1'b0, 4, 3, 1'b0, "div4");

      // Writes during a run must not disturb it.
      sin = 1'($urandom_range(0, 1));
      d   = $urandom;
      wr(8'h04, d);
      wr(8'h0C, 32'd1);
      ser_in = sin;
      wr(8'h00, 32'h0801);
      s = acc_edge;
      wr(8'h04, 32'hDEAD_BEEF);
      wr(8'h0C, 32'd7);
      wr(8'h00, 32'h0203);
      wait_n = 0;
      for (int g = 0; g < 200 && busy; g++) begin
         @(posedge clock);
         #1;
      end
      wait_n = int'(cyc_n - s);
      check("prot_dur", wait_n, 16);
      rd(8'h04, ref_sr(d, 1'b0, sin, 8), "prot_data");
      rd(8'h00, 32'h0202, "prot_ctrl");
      rd(8'h0C, 32'd1, "prot_div");
      check("prot_irq", {31'b0, irq}, 1);
      wr(8'h08, 32'h2);
      rd(8'h08, 32'h0, "w1c_status");
      check("w1c_irq", {31'b0, irq}, 0);

      do_run($urandom, 1'b0, 40, 0, 1'b1, "len40");
      rd(8'h00, 32'h2800, "len40_ctrl");
      wr(8'h08, 32'h2);
      do_run(32'hA5A5_5A5A, 1'b1, 0, 2, 1'b1, "len0");

      wr(8'h04, 32'h1122_3344);
      wr(8'h04, 32'hAABB_CCDD, 4'b0101);
      rd(8'h04, 32'h11BB_33DD, "sel_data");

      rd(8'h10, 32'h0, "unmapped_rd");
      wr(8'h14, 32'hFFFF_FFFF);
      rd(8'h04, 32'h11BB_33DD, "unmapped_wr");
      bus(1'b0, 32'h3000_1000, '0, 4'hF, '0, "far", 1'b0);

      for (int i = 0; i < 8; i++)
         do_run($urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 40), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), "rand");

      // Abort a run with an asynchronous reset pulse.
      wr(8'h04, 32'hFFFF_0000);
      wr(8'h0C, 32'd2);
      wr(8'h00, 32'h1401);
      repeat (5) @(posedge clock);
      #2;
      resetb = 1'b0;
      #1;
      check("abort_busy", {31'b0, busy}, 0);
      check("abort_irq", {31'b0, irq}, 0);
      check("abort_ser", {31'b0, ser_out}, 0);
      @(negedge clock);
      resetb = 1'b1;
      @(posedge clock);
      #1;
      rd(8'h04, 0, "abort_data");
      rd(8'h08, 0, "abort_status");
      rd(8'h00, 0, "abort_ctrl");
      rd(8'h0C, 0, "abort_div");
      do_run(32'h0F0F_F0F0, 1'b1, 12, 1, 1'b1, "post_abort");

      repeat (3) @(posedge clock);
      #1;
      check("sb_drain", q_rd.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/sr_wb_shift_reg.md
Name: sr_wb_shift_reg

Overview:
- Wishbone-slave serial shift-register peripheral in the Caravel user project area.
- Management-SoC firmware loads a parallel word, configures direction, length and rate, then starts a shift run.
- Bits leave on `ser_out` and are captured from `ser_in`; busy/done status and an IRQ report completion.
- Firmware signals pass/fail on mprj_io[1:0] (0x1 = started, 0x2 = passed); that signalling is outside this block.

Parameters:
- WIDTH, 32, shift-register and Wishbone data width (fixed at 32 for this register map).
- BASE_ADDR, 32'h3000_0000, base address; decode matches adr[31:4] only.

Ports:
- clock  input  1  system/Wishbone clock
- resetb  input  1  asynchronous active-low reset
- wbs_cyc_i  input  1  Wishbone cycle
- wbs_stb_i  input  1  Wishbone strobe
- wbs_we_i  input  1  write enable
- wbs_sel_i  input  4  byte selects
- wbs_adr_i  input  32  byte address
- wbs_dat_i  input  32  write data
- wbs_ack_o  output  1  acknowledge
- wbs_dat_o  output  32  read data
- ser_in  input  1  serial data in
- ser_out  output  1  serial data out
- busy  output  1  shift run in progress
- irq  output  1  level interrupt, equals STATUS.done

Behaviour:
- Reset (resetb low, asynchronous): all registers, counters, ack, wbs_dat_o, busy and done are cleared to 0.

Register map (offsets from BASE_ADDR):
- 0x00 CTRL
  - [0] START: write-1 triggers a run; reads 0.
  - [1] DIR: 0 = shift left, MSB out; 1 = shift right, LSB out.
  - [13:8] LEN: number of shifts. 0 = run completes immediately; values >32 clamp to 32.
- 0x04 DATA
  - Write loads the shift register; ignored while busy.
  - Read returns the live shift register.
- 0x08 STATUS
  - [0] busy (read-only).
  - [1] done: sticky; write-1-to-clear.
  - [13:8] remaining shift count (read-only).
- 0x0C DIV [15:0]: one shift every DIV+1 clocks. Writes are ignored while busy.

Wishbone:
- Access = cyc & stb & address match.
- ack asserts exactly 1 cycle after the access is seen, for 1 cycle only; it is never asserted two consecutive cycles.
- Read data is valid with ack.
- wbs_sel_i masks bytes on DATA/DIV/CTRL writes.
- Unmapped offsets and non-matching-but-acked addresses: ack, read 0, writes ignored.
- A non-matching address produces no ack.

State machine IDLE/SHIFT:
- IDLE -> SHIFT on START=1 written while idle with LEN>0: busy=1, cnt=LEN, tick=0, done=0.
- START with LEN=0 while idle: done=1 on the next cycle, no shifting.
- START written while busy is ignored.
- In SHIFT, tick counts 0..DIV. When tick==DIV:
  - DIR=0: sr <= {sr[30:0], ser_in}.
  - DIR=1: sr <= {ser_in, sr[31:1]}.
  - cnt decrements and tick resets to 0.
- When cnt reaches 0: SHIFT -> IDLE, busy=0, done=1 (same edge as the last shift).
- ser_out is combinational: sr[31] when DIR=0, sr[0] when DIR=1.
- DIR is latched at START; CTRL writes during a run do not affect it.
- Simultaneous completion and done W1C: set wins.
- Reset mid-run: aborts immediately; all state returns to the reset values.

Test Plan:
- Reset check: after resetb release, reads of 0x00/0x04/0x08/0x0C return 0; ser_out=0; irq=0; each access acks exactly once, 1 cycle after strobe.
- Left shift: DATA=0x000000A5, DIV=0, ser_in=1, CTRL=0x0801 -> busy for exactly 8 cycles; DATA=0x0000A5FF; STATUS=0x2; irq=1; ser_out=0 throughout.
- Right shift: DATA=0x80000001, ser_in=0, CTRL=0x0103 -> ser_out=1 before the shift; DATA=0x40000000; done=1.
- Divider: DIV=3, LEN=4 -> shift edges every 4 clocks; busy for 16 cycles; STATUS[13:8] reads 4,3,2,1,0 along the run.
- Protection and clearing:
  - Write DATA while busy -> no effect.
  - Write STATUS=0x2 -> done and irq clear.
  - LEN=40 -> clamps to 32 shifts.
  - Read offset 0x10 -> 0 with ack.
- Abort: pulse resetb low mid-run -> busy=0, DATA=0 asynchronously; a new run then works normally.
